// File: rtl/product_accumulator.sv
// product_accumulator
// Multiply-accumulate back end: sums a burst of COUNT_MAX unsigned 7-bit
// products into a saturating ACC_W-bit accumulator, then holds the final sum
// until downstream takes it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   clear      synchronous abort: drop the burst, restart accumulation
//   P_in       unsigned product from the multiplier
//   p_valid    P_in is valid this cycle
//   p_ready    block accepts P_in this cycle
//   acc_out    registered running / final sum
//   acc_valid  burst complete, acc_out is final (asserted exactly in HOLD)
//   acc_ready  downstream takes the final sum
//   count      products accepted in the current burst
//   ovf        sticky: the sum saturated during the current burst
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The input side never lowers p_ready because of p_valid; the
// only input reaching p_ready combinationally is clear. acc_ready only
// affects registered state, never an output in the same cycle.
module product_accumulator #(
   parameter int ACC_W     = 10,
   parameter int COUNT_MAX = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [6:0]       P_in,
   input  logic             p_valid,
   output logic             p_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [3:0]       count,
   output logic             ovf
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t state;

   localparam logic [3:0] LAST_IDX = 4'(COUNT_MAX - 1);

   logic             accept;
   logic [ACC_W:0]   sum;

   // ACC_W+1 bit add: the carry bit flags that the true sum passed the
   // representable maximum.
   assign sum = {1'b0, acc_out} + {{(ACC_W - 6){1'b0}}, P_in};

   assign p_ready = (state == ACCUM) && !clear;
   assign accept  = p_valid && p_ready;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         // clear shares the reset behaviour; it also outranks accept and
         // acc_ready because it is tested first.
         state     <= ACCUM;
         acc_out   <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         acc_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  if (sum[ACC_W]) begin
                     acc_out <= '1;
                     ovf     <= 1'b1;
                  end else begin
                     acc_out <= sum[ACC_W-1:0];
                  end
                  count <= count + 4'd1;
                  if (count == LAST_IDX) begin
                     state     <= HOLD;
                     acc_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (acc_ready) begin
                  state     <= ACCUM;
                  acc_out   <= '0;
                  count     <= '0;
                  ovf       <= 1'b0;
                  acc_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ACCUM;
               acc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed bench for product_accumulator. Instance "a" uses the default
// parameters (ACC_W=10, COUNT_MAX=8); instance "b" uses COUNT_MAX=12 for the
// saturation burst. Both share inputs; each scenario starts from reset.
// Inputs are driven and outputs sampled on the falling edge.
module tb_product_accumulator;

   logic       clk;
   logic       rst;
   logic       clear;
   logic [6:0] P_in;
   logic       p_valid;
   logic       acc_ready;

   logic       p_ready_a, acc_valid_a, ovf_a;
   logic [9:0] acc_out_a;
   logic [3:0] count_a;

   logic       p_ready_b, acc_valid_b, ovf_b;
   logic [9:0] acc_out_b;
   logic [3:0] count_b;

   int checks;
   int failures;

   product_accumulator #(.ACC_W(10), .COUNT_MAX(8)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .P_in(P_in), .p_valid(p_valid),
      .p_ready(p_ready_a), .acc_out(acc_out_a), .acc_valid(acc_valid_a),
      .acc_ready(acc_ready), .count(count_a), .ovf(ovf_a)
   );

   product_accumulator #(.ACC_W(10), .COUNT_MAX(12)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .P_in(P_in), .p_valid(p_valid),
      .p_ready(p_ready_b), .acc_out(acc_out_b), .acc_valid(acc_valid_b),
      .acc_ready(acc_ready), .count(count_b), .ovf(ovf_b)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; p_valid = 1'b0; P_in = '0; acc_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // one accept on instance a, then compare running sum and count
   task automatic accept_a(input logic [6:0] v, input int exp_sum, input int exp_cnt);
      p_valid = 1'b1; P_in = v;
      #1 check("a_p_ready_accum", p_ready_a, 1);
      tick();
      p_valid = 1'b0;
      check("a_acc_out_step", acc_out_a, exp_sum);
      check("a_count_step", count_a, exp_cnt);
   endtask

   logic [6:0] nom_p [8];
   int         nom_s [8];
   int         sat_exp;

   initial begin
      checks = 0; failures = 0;
      nom_p = '{7'd6, 7'd15, 7'd0, 7'd105, 7'd42, 7'd1, 7'd7, 7'd20};
      nom_s = '{6, 21, 21, 126, 168, 169, 176, 196};
      rst = 1'b0; clear = 1'b0; p_valid = 1'b0; P_in = '0; acc_ready = 1'b0;
      tick();

      // reset with valid traffic present
      rst = 1'b1; p_valid = 1'b1; P_in = 7'd105;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_acc_out", acc_out_a, 0);
         check("rst_count", count_a, 0);
         check("rst_ovf", ovf_a, 0);
         check("rst_acc_valid", acc_valid_a, 0);
      end
      rst = 1'b0; p_valid = 1'b0;
      #1 check("rst_release_p_ready", p_ready_a, 1);

      // nominal burst
      for (int i = 0; i < 8; i++) begin
         if (i < 7) accept_a(nom_p[i], nom_s[i], i + 1);
         else begin
            accept_a(nom_p[i], nom_s[i], i + 1);
         end
         if (i < 7) check("nom_acc_valid_low", acc_valid_a, 0);
      end
      check("nom_acc_valid", acc_valid_a, 1);
      check("nom_count_final", count_a, 8);
      check("nom_ovf", ovf_a, 0);

      // backpressure in HOLD
      p_valid = 1'b1; P_in = 7'd33; acc_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 check("hold_p_ready", p_ready_a, 0);
         tick();
         check("hold_acc_out", acc_out_a, 196);
         check("hold_acc_valid", acc_valid_a, 1);
      end
      p_valid = 1'b0; acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      check("release_acc_valid", acc_valid_a, 0);
      check("release_acc_out", acc_out_a, 0);
      check("release_count", count_a, 0);
      #1 check("release_p_ready", p_ready_b, 1);
      check("release_p_ready_a", p_ready_a, 1);

      // saturation on the 12-product instance
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         p_valid = 1'b1; P_in = 7'd105;
         #1 check("sat_p_ready", p_ready_b, 1);
         tick();
         sat_exp = (105 * k > 1023) ? 1023 : 105 * k;
         check("sat_acc_out", acc_out_b, sat_exp);
         check("sat_ovf", ovf_b, (k >= 10) ? 1 : 0);
      end
      p_valid = 1'b0;
      check("sat_acc_valid", acc_valid_b, 1);
      check("sat_final_acc", acc_out_b, 1023);
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      check("sat_ovf_cleared", ovf_b, 0);
      check("sat_acc_valid_cleared", acc_valid_b, 0);

      // mid-burst clear with simultaneous valid
      do_reset();
      accept_a(7'd6, 6, 1);
      accept_a(7'd15, 21, 2);
      accept_a(7'd0, 21, 3);
      clear = 1'b1; p_valid = 1'b1; P_in = 7'd50;
      #1 check("clear_p_ready", p_ready_a, 0);
      tick();
      clear = 1'b0; p_valid = 1'b0;
      check("clear_acc_out", acc_out_a, 0);
      check("clear_count", count_a, 0);
      accept_a(7'd50, 50, 1);

      // gapped input
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         accept_a(7'd10, 10 * i, i);
         if (i < 8) begin
            check("gap_acc_valid_low", acc_valid_a, 0);
            P_in = 7'd99;
            tick();
            check("gap_idle_acc_out", acc_out_a, 10 * i);
            check("gap_idle_acc_valid", acc_valid_a, 0);
         end
      end
      check("gap_acc_valid", acc_valid_a, 1);
      check("gap_acc_out", acc_out_a, 80);

      // clear outranks acc_ready in HOLD
      clear = 1'b1; acc_ready = 1'b1;
      #1 check("hold_clear_p_ready", p_ready_a, 0);
      tick();
      clear = 1'b0; acc_ready = 1'b0;
      check("hold_clear_acc_valid", acc_valid_a, 0);
      check("hold_clear_count", count_a, 0);
      check("hold_clear_acc_out", acc_out_a, 0);
      #1 check("hold_clear_p_ready_after", p_ready_a, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
